// File: rtl/bram_copy_pkg.sv
// Shared constants for the BlockRam copy/fill engine: FSM state codes,
// command mode encodings and the full-word byte-enable value.
package bram_copy_pkg;

  // FSM state codes
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FILL  = 3'd1;
  localparam logic [2:0] ST_CPRD  = 3'd2;
  localparam logic [2:0] ST_CPRUN = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // Command mode encodings
  localparam logic MODE_FILL = 1'b0;
  localparam logic MODE_COPY = 1'b1;

  // Both byte lanes enabled (copy always writes whole words)
  localparam logic [1:0] BE_FULL = 2'b11;

endpackage

// File: rtl/bram_addr_gen.sv
// Loadable up/down address counter, modulo 2**ADDR_BITS, that also tracks
// the number of addresses still to be issued. tc is high while the
// currently presented address is the last one of the run.
module bram_addr_gen #(
  parameter int ADDR_BITS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 step,
  input  logic                 down,
  input  logic [ADDR_BITS-1:0] load_addr,
  input  logic [ADDR_BITS:0]   load_count,
  output logic [ADDR_BITS-1:0] addr,
  output logic                 tc
);

  localparam logic [ADDR_BITS-1:0] ADDR_ONE  = {{(ADDR_BITS-1){1'b0}}, 1'b1};
  localparam logic [ADDR_BITS:0]   COUNT_ONE = {{ADDR_BITS{1'b0}}, 1'b1};
  localparam logic [ADDR_BITS:0]   COUNT_ZERO = {(ADDR_BITS+1){1'b0}};

  logic [ADDR_BITS-1:0] addr_r;
  logic [ADDR_BITS:0]   count_r;

  // Address/remaining-count register; the adder drops its carry so the
  // address wraps naturally at the top of the RAM.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_r  <= {ADDR_BITS{1'b0}};
      count_r <= COUNT_ZERO;
    end else if (load) begin
      addr_r  <= load_addr;
      count_r <= load_count;
    end else if (step) begin
      addr_r <= down ? (addr_r - ADDR_ONE) : (addr_r + ADDR_ONE);
      if (count_r != COUNT_ZERO) begin
        count_r <= count_r - COUNT_ONE;
      end else begin
        count_r <= COUNT_ZERO;
      end
    end else begin
      addr_r  <= addr_r;
      count_r <= count_r;
    end
  end

  assign addr = addr_r;
  assign tc   = (count_r == COUNT_ONE);

endmodule

// File: rtl/bram_copy_engine.sv
// Bulk-transfer master for the dual-port BlockRam: block fill (constant
// pattern with byte mask) and block copy, one word per clock. Port A is
// the read port, port B the write port.
// Optional build macro BRAM_COPY_DESC_EN: copies whose destination
// overlaps ahead of the source run in descending order (memmove).
module bram_copy_engine
  import bram_copy_pkg::*;
#(
  parameter  int WORDS     = 16,
  localparam int ADDR_BITS = $clog2(WORDS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 mode,
  input  logic [ADDR_BITS-1:0] src_addr,
  input  logic [ADDR_BITS-1:0] dst_addr,
  input  logic [ADDR_BITS:0]   len,
  input  logic [15:0]          fill_data,
  input  logic [1:0]           fill_be,
  output logic                 busy,
  output logic                 done,
  output logic [ADDR_BITS-1:0] ram_a_addr,
  input  logic [15:0]          ram_a_q,
  output logic [ADDR_BITS-1:0] ram_b_addr,
  output logic                 ram_b_wr_en,
  output logic [1:0]           ram_b_be,
  output logic [15:0]          ram_b_wdata
);

  localparam logic [ADDR_BITS:0]   LEN_MAX   = (ADDR_BITS+1)'(WORDS);
  localparam logic [ADDR_BITS:0]   LEN_ZERO  = {(ADDR_BITS+1){1'b0}};
  localparam logic [ADDR_BITS:0]   LEN_ONE   = {{ADDR_BITS{1'b0}}, 1'b1};
  localparam logic [ADDR_BITS-1:0] ADDR_ONE  = {{(ADDR_BITS-1){1'b0}}, 1'b1};

  logic [2:0]           state_r;
  logic                 busy_r;
  logic                 done_r;
  logic                 wr_en_r;
  logic [1:0]           be_r;
  logic [15:0]          wdata_r;
  logic                 desc_r;

  logic                 accept_s;
  logic                 len_nz_s;
  logic                 desc_s;
  logic [ADDR_BITS:0]   len_clamp_s;
  logic [ADDR_BITS-1:0] len_m1_s;
  logic [ADDR_BITS-1:0] rd_base_s;
  logic [ADDR_BITS-1:0] wr_base_s;
  logic                 rd_load_s;
  logic                 wr_load_s;
  logic                 rd_step_s;
  logic                 wr_step_s;
  logic                 rd_tc_s;
  logic                 wr_tc_s;

  // Command decode: clamp the length and work out the starting addresses.
  assign accept_s    = (state_r == ST_IDLE) && start;
  assign len_clamp_s = (len > LEN_MAX) ? LEN_MAX : len;
  assign len_nz_s    = (len_clamp_s != LEN_ZERO);
  assign len_m1_s    = len_clamp_s[ADDR_BITS-1:0] - ADDR_ONE;

`ifdef BRAM_COPY_DESC_EN
  logic [ADDR_BITS-1:0] diff_s;
  // A destination lying ahead of the source inside the block would be
  // clobbered by an ascending copy, so such copies run top-down.
  assign diff_s = dst_addr - src_addr;
  assign desc_s = (mode == MODE_COPY) && (diff_s != {ADDR_BITS{1'b0}})
                  && ({1'b0, diff_s} < len_clamp_s);
`else
  assign desc_s = 1'b0;
`endif

  assign rd_base_s = desc_s ? (src_addr + len_m1_s) : src_addr;
  assign wr_base_s = desc_s ? (dst_addr + len_m1_s) : dst_addr;

  // The read side issues one extra address (the prime cycle), so it
  // carries len+1 steps; both sides reach terminal count together.
  assign rd_load_s = accept_s && (mode == MODE_COPY) && len_nz_s;
  assign wr_load_s = accept_s && len_nz_s;
  assign rd_step_s = (state_r == ST_CPRD) || (state_r == ST_CPRUN);
  assign wr_step_s = (state_r == ST_FILL) || (state_r == ST_CPRUN);

  bram_addr_gen #(.ADDR_BITS(ADDR_BITS)) u_rd_gen (
    .clk        (clk),
    .reset      (reset),
    .load       (rd_load_s),
    .step       (rd_step_s),
    .down       (desc_r),
    .load_addr  (rd_base_s),
    .load_count (len_clamp_s + LEN_ONE),
    .addr       (ram_a_addr),
    .tc         (rd_tc_s)
  );

  bram_addr_gen #(.ADDR_BITS(ADDR_BITS)) u_wr_gen (
    .clk        (clk),
    .reset      (reset),
    .load       (wr_load_s),
    .step       (wr_step_s),
    .down       (desc_r),
    .load_addr  (wr_base_s),
    .load_count (len_clamp_s),
    .addr       (ram_b_addr),
    .tc         (wr_tc_s)
  );

  // Sequencer FSM with registered status and write-control outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      wr_en_r <= 1'b0;
      be_r    <= BE_FULL;
      wdata_r <= 16'h0000;
      desc_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            wdata_r <= fill_data;
            be_r    <= (mode == MODE_COPY) ? BE_FULL : fill_be;
            desc_r  <= desc_s;
            if (!len_nz_s) begin
              state_r <= ST_DONE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
              wr_en_r <= 1'b0;
            end else if (mode == MODE_FILL) begin
              state_r <= ST_FILL;
              busy_r  <= 1'b1;
              wr_en_r <= 1'b1;
            end else begin
              state_r <= ST_CPRD;
              busy_r  <= 1'b1;
              wr_en_r <= 1'b0;
            end
          end else begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            wr_en_r <= 1'b0;
          end
        end
        ST_FILL: begin
          if (wr_tc_s) begin
            state_r <= ST_DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            wr_en_r <= 1'b0;
          end else begin
            state_r <= ST_FILL;
          end
        end
        ST_CPRD: begin
          state_r <= ST_CPRUN;
          wr_en_r <= 1'b1;
        end
        ST_CPRUN: begin
          if (wr_tc_s && rd_tc_s) begin
            state_r <= ST_DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            wr_en_r <= 1'b0;
          end else begin
            state_r <= ST_CPRUN;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          wr_en_r <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          wr_en_r <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_r;
  assign done        = done_r;
  assign ram_b_wr_en = wr_en_r;
  assign ram_b_be    = be_r;
  // During a copy the write data is the RAM's own registered read output,
  // so the path stays register-to-port with no extra pipeline stage.
  assign ram_b_wdata = (state_r == ST_CPRUN) ? ram_a_q : wdata_r;

endmodule

// File: tb/tb_bram_copy_engine.sv
// Directed testbench for bram_copy_engine with a behavioural BlockRam
// model (port A read with one-cycle latency and port B->A bypass).
module tb_bram_copy_engine;

  localparam int WORDS = 16;
  localparam int AB    = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          mode;
  logic [AB-1:0] src_addr;
  logic [AB-1:0] dst_addr;
  logic [AB:0]   len;
  logic [15:0]   fill_data;
  logic [1:0]    fill_be;
  logic          busy;
  logic          done;
  logic [AB-1:0] ram_a_addr;
  logic [15:0]   ram_a_q;
  logic [AB-1:0] ram_b_addr;
  logic          ram_b_wr_en;
  logic [1:0]    ram_b_be;
  logic [15:0]   ram_b_wdata;

  int total = 0;
  int bad   = 0;
  int wr_cnt = 0;

  logic [15:0]   mem [WORDS];
  logic          poke_en = 1'b0;
  logic [AB-1:0] poke_addr;
  logic [15:0]   poke_data;

  always #5 clk = ~clk;

  bram_copy_engine #(.WORDS(WORDS)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
    .fill_data(fill_data), .fill_be(fill_be), .busy(busy), .done(done),
    .ram_a_addr(ram_a_addr), .ram_a_q(ram_a_q),
    .ram_b_addr(ram_b_addr), .ram_b_wr_en(ram_b_wr_en),
    .ram_b_be(ram_b_be), .ram_b_wdata(ram_b_wdata)
  );

  function automatic logic [15:0] merge(input logic [15:0] old_w,
                                        input logic [15:0] new_w,
                                        input logic [1:0]  be);
    merge = {be[1] ? new_w[15:8] : old_w[15:8], be[0] ? new_w[7:0] : old_w[7:0]};
  endfunction

  // BlockRam model: byte-masked write on port B, registered read on port A
  // that returns the word being written when both ports hit one address.
  always @(posedge clk) begin
    if (poke_en) begin
      mem[poke_addr] <= poke_data;
    end
    if (ram_b_wr_en) begin
      mem[ram_b_addr] <= merge(mem[ram_b_addr], ram_b_wdata, ram_b_be);
      wr_cnt <= wr_cnt + 1;
    end
    if (ram_b_wr_en && (ram_b_addr == ram_a_addr)) begin
      ram_a_q <= merge(mem[ram_b_addr], ram_b_wdata, ram_b_be);
    end else begin
      ram_a_q <= mem[ram_a_addr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [AB-1:0] a, input logic [15:0] d);
    poke_addr = a;
    poke_data = d;
    poke_en   = 1'b1;
    tick();
    poke_en   = 1'b0;
  endtask

  // Drive a command for one clock; returns at the sample of cycle 1.
  task automatic issue(input logic m, input logic [AB-1:0] s, input logic [AB-1:0] d,
                       input logic [AB:0] l, input logic [15:0] fd, input logic [1:0] fb);
    mode = m; src_addr = s; dst_addr = d; len = l; fill_data = fd; fill_be = fb;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Bounded wait for done; n_done = -1 if it never arrives.
  task automatic wait_done(input int n0, output int n_done, output int busy_n);
    int n;
    n = n0;
    n_done = -1;
    busy_n = 0;
    while ((n < 64) && (n_done < 0)) begin
      if (busy) busy_n++;
      if (done) begin
        n_done = n;
      end else begin
        tick();
        n++;
      end
    end
  endtask

  initial begin
    int nd;
    int nb;
    int w0;
    int dcnt;
    reset = 1'b1; start = 1'b0; mode = 1'b0; src_addr = 4'd0; dst_addr = 4'd0;
    len = 5'd0; fill_data = 16'h0000; fill_be = 2'b00;
    for (int i = 0; i < WORDS; i++) poke(4'(i), 16'h0100 + 16'(i));
    tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_wr_en", {31'd0, ram_b_wr_en}, 32'd0);
    chk("rst_be", {30'd0, ram_b_be}, 32'd3);
    chk("rst_wdata", {16'd0, ram_b_wdata}, 32'd0);
    chk("rst_a_addr", {28'd0, ram_a_addr}, 32'd0);
    chk("rst_b_addr", {28'd0, ram_b_addr}, 32'd0);
    reset = 1'b0;
    tick();

    // Fill dst=2 len=4
    w0 = wr_cnt;
    issue(1'b0, 4'd0, 4'd2, 5'd4, 16'hA5A5, 2'b11);
    wait_done(1, nd, nb);
    chk("fill_done_cycle", nd, 32'd5);
    chk("fill_busy_cycles", nb, 32'd4);
    tick();
    chk("fill_done_pulse", {31'd0, done}, 32'd0);
    chk("fill_writes", wr_cnt - w0, 32'd4);
    for (int i = 2; i < 6; i++) chk("fill_word", {16'd0, mem[i]}, 32'h0000A5A5);
    chk("fill_below", {16'd0, mem[1]}, 32'h00000101);
    chk("fill_above", {16'd0, mem[6]}, 32'h00000106);

    // Byte-masked fill
    poke(4'd8, 16'hFFFF);
    issue(1'b0, 4'd0, 4'd8, 5'd1, 16'h0012, 2'b01);
    wait_done(1, nd, nb);
    chk("mask_done_cycle", nd, 32'd2);
    tick();
    chk("mask_word", {16'd0, mem[8]}, 32'h0000FF12);

    // Copy 0..3 -> 10..13
    for (int i = 0; i < 4; i++) poke(4'(i), 16'h1000 + 16'(i));
    w0 = wr_cnt;
    issue(1'b1, 4'd0, 4'd10, 5'd4, 16'h0000, 2'b00);
    wait_done(1, nd, nb);
    chk("copy_done_cycle", nd, 32'd6);
    chk("copy_busy_cycles", nb, 32'd5);
    tick();
    chk("copy_writes", wr_cnt - w0, 32'd4);
    for (int i = 0; i < 4; i++) chk("copy_word", {16'd0, mem[10 + i]}, 32'h1000 + i);

    // Wrapping copy 0..3 -> 14,15,0,1 (sources read before being overwritten)
    issue(1'b1, 4'd0, 4'd14, 5'd4, 16'h0000, 2'b00);
    wait_done(1, nd, nb);
    chk("wrap_done_cycle", nd, 32'd6);
    tick();
    chk("wrap_14", {16'd0, mem[14]}, 32'h1000);
    chk("wrap_15", {16'd0, mem[15]}, 32'h1001);
    chk("wrap_0", {16'd0, mem[0]}, 32'h1002);
    chk("wrap_1", {16'd0, mem[1]}, 32'h1003);
    chk("wrap_2", {16'd0, mem[2]}, 32'h1002);

    // Zero length
    w0 = wr_cnt;
    issue(1'b0, 4'd0, 4'd3, 5'd0, 16'hDEAD, 2'b11);
    wait_done(1, nd, nb);
    chk("len0_done_cycle", nd, 32'd1);
    chk("len0_busy", nb, 32'd0);
    tick();
    tick();
    chk("len0_writes", wr_cnt - w0, 32'd0);

    // Start while busy and in the DONE cycle are both ignored
    w0 = wr_cnt;
    issue(1'b0, 4'd0, 4'd4, 5'd3, 16'h5555, 2'b11);
    mode = 1'b0; dst_addr = 4'd12; len = 5'd2; fill_data = 16'h7777; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(2, nd, nb);
    chk("busy_start_done_cycle", nd, 32'd4);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("done_start_busy", {31'd0, busy}, 32'd0);
    tick();
    tick();
    chk("ignored_writes", wr_cnt - w0, 32'd3);
    chk("ignored_word12", {16'd0, mem[12]}, 32'h1002);
    for (int i = 4; i < 7; i++) chk("busy_fill_word", {16'd0, mem[i]}, 32'h5555);

    // Overlapping copy src=0 dst=1 len=3
    for (int i = 0; i < 4; i++) poke(4'(i), 16'(i + 1));
    issue(1'b1, 4'd0, 4'd1, 5'd3, 16'h0000, 2'b00);
    wait_done(1, nd, nb);
    chk("ovl_done_cycle", nd, 32'd5);
    tick();
    chk("ovl_0", {16'd0, mem[0]}, 32'd1);
`ifdef BRAM_COPY_DESC_EN
    chk("ovl_1", {16'd0, mem[1]}, 32'd1);
    chk("ovl_2", {16'd0, mem[2]}, 32'd2);
    chk("ovl_3", {16'd0, mem[3]}, 32'd3);
`else
    chk("ovl_1", {16'd0, mem[1]}, 32'd1);
    chk("ovl_2", {16'd0, mem[2]}, 32'd1);
    chk("ovl_3", {16'd0, mem[3]}, 32'd1);
`endif

    // Length above WORDS clamps to a full-RAM fill
    w0 = wr_cnt;
    issue(1'b0, 4'd0, 4'd5, 5'd20, 16'h3C3C, 2'b11);
    wait_done(1, nd, nb);
    chk("clamp_done_cycle", nd, 32'd17);
    tick();
    chk("clamp_writes", wr_cnt - w0, 32'd16);
    chk("clamp_word4", {16'd0, mem[4]}, 32'h3C3C);

    // Reset mid-transfer
    poke(4'd3, 16'h0BAD);
    w0 = wr_cnt;
    issue(1'b0, 4'd0, 4'd0, 5'd8, 16'h9999, 2'b11);
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("rstmid_wr_en", {31'd0, ram_b_wr_en}, 32'd0);
    chk("rstmid_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) dcnt++;
      tick();
    end
    chk("rstmid_no_done", dcnt, 32'd0);
    chk("rstmid_writes", wr_cnt - w0, 32'd3);
    chk("rstmid_word2", {16'd0, mem[2]}, 32'h9999);
    chk("rstmid_word3", {16'd0, mem[3]}, 32'h0BAD);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
